// File: rtl/rom_fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, reads a zero-latency ROM and
// queues {instruction, pc} pairs in a 2-entry buffer for the decode stage.
module rom_fetch_sequencer #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_dataout,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              running,
  output logic              wrap_pulse,
  output logic [CNT_W-1:0]  fetch_count
);

  localparam int unsigned CNT_BUF_W = 2;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [ADDR_W-1:0]      r_pc;
  logic [CNT_BUF_W-1:0]   r_count;
  logic [CNT_BUF_W-1:0]   w_count_nxt;
  entry_t                 r_head;
  entry_t                 r_tail;
  entry_t                 w_entry;
  logic                   r_wrap;
  logic [CNT_W-1:0]       r_fetch_cnt;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_full;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus handshake decisions for this cycle
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_push      = 1'b0;
    w_full      = (r_count == CNT_BUF_W'(2));
    w_entry     = '{data: rom_dataout, pc: r_pc};

    case (r_state)
      ST_RUN:  if (halt)  w_state_nxt = ST_HALT;
      ST_HALT: if (!halt) w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_RUN;
    endcase

    w_pop  = (r_count != CNT_BUF_W'(0)) & instr_ready;
    w_push = (r_state == ST_RUN) & ~halt & ~redirect_valid & (~w_full | w_pop);
  end

  // Occupancy: a redirect flushes regardless of any pop/push
  always_comb begin
    w_count_nxt = r_count;
    if (redirect_valid) begin
      w_count_nxt = CNT_BUF_W'(0);
    end else begin
      case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + CNT_BUF_W'(1);
        2'b01:   w_count_nxt = r_count - CNT_BUF_W'(1);
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // PC, buffer and status datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc        <= ADDR_W'(RESET_PC);
      r_count     <= CNT_BUF_W'(0);
      r_head      <= '0;
      r_tail      <= '0;
      r_wrap      <= 1'b0;
      r_fetch_cnt <= '0;
    end else begin
      r_count <= w_count_nxt;
      r_wrap  <= w_push & (r_pc == {ADDR_W{1'b1}});

      if (redirect_valid) begin
        r_pc <= redirect_pc;
      end else if (w_push) begin
        r_pc <= r_pc + ADDR_W'(1);
      end

      if (w_push && (r_fetch_cnt != {CNT_W{1'b1}})) begin
        r_fetch_cnt <= r_fetch_cnt + CNT_W'(1);
      end

      // Head advances from tail when full; otherwise a push lands in the
      // head if it is (or is about to become) empty. A lone pop at count 1
      // leaves the head untouched so the outputs hold their last value.
      if (w_pop && w_full) begin
        r_head <= r_tail;
      end else if (w_push && ((r_count == CNT_BUF_W'(0)) ||
                              (w_pop && (r_count == CNT_BUF_W'(1))))) begin
        r_head <= w_entry;
      end

      if (w_push && (w_full || ((r_count == CNT_BUF_W'(1)) && !w_pop))) begin
        r_tail <= w_entry;
      end
    end
  end

  assign rom_address = r_pc;
  assign instr_valid = (r_count != CNT_BUF_W'(0));
  assign instr_data  = r_head.data;
  assign instr_pc    = r_head.pc;
  assign running     = (r_state == ST_RUN);
  assign wrap_pulse  = r_wrap;
  assign fetch_count = r_fetch_cnt;

endmodule

// File: tb/tb_rom_fetch_sequencer.sv
// Bench for rom_fetch_sequencer: directed scenarios then random traffic,
// every cycle compared against a queue-based model of the fetch pipeline.
module tb_rom_fetch_sequencer;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] rom_address;
  logic [DATA_W-1:0] rom_dataout;
  logic              instr_valid;
  logic [DATA_W-1:0] instr_data;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_ready;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halt;
  logic              running;
  logic              wrap_pulse;
  logic [CNT_W-1:0]  fetch_count;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int q_pc[$];
  int m_pc;
  bit m_run;
  int m_fc;
  bit m_wrap;

  always #5 clk = ~clk;

  assign rom_dataout = rom_address ^ 8'hA5;

  rom_fetch_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(0), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rom_address(rom_address), .rom_dataout(rom_dataout),
    .instr_valid(instr_valid), .instr_data(instr_data), .instr_pc(instr_pc),
    .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt), .running(running), .wrap_pulse(wrap_pulse),
    .fetch_count(fetch_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of the fetch pipeline described as queue operations
  task automatic model_step();
    bit pop;
    bit push;
    if (!rst_n) begin
      q_pc.delete();
      m_pc = 0; m_run = 1'b1; m_fc = 0; m_wrap = 1'b0;
      return;
    end
    pop  = (q_pc.size() > 0) && instr_ready;
    push = m_run && !halt && !redirect_valid && ((q_pc.size() < 2) || pop);
    if (pop) void'(q_pc.pop_front());
    m_wrap = 1'b0;
    if (redirect_valid) begin
      q_pc.delete();
      m_pc = int'(redirect_pc);
    end else if (push) begin
      q_pc.push_back(m_pc);
      m_wrap = (m_pc == 255);
      m_pc = (m_pc + 1) % 256;
      if (m_fc < 65535) m_fc++;
    end
    m_run = !halt;
  endtask

  task automatic compare();
    check("instr_valid", 32'(instr_valid), 32'(q_pc.size() != 0));
    check("running",     32'(running),     32'(m_run));
    check("rom_address", 32'(rom_address), 32'(m_pc));
    check("wrap_pulse",  32'(wrap_pulse),  32'(m_wrap));
    check("fetch_count", 32'(fetch_count), 32'(m_fc));
    if (q_pc.size() != 0) begin
      check("instr_pc",   32'(instr_pc),   32'(q_pc[0]));
      check("instr_data", 32'(instr_data), 32'((q_pc[0] ^ 'hA5) & 'hFF));
    end
  endtask

  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_step();
      #1;
      compare();
    end
  endtask

  initial begin
    rst_n = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; halt = 1'b0;
    @(negedge clk);

    // Reset state
    cyc(2);
    check("rst_pc",   32'(instr_pc),   32'h0);
    check("rst_data", 32'(instr_data), 32'h0);

    // Stream at full rate
    rst_n = 1'b1; instr_ready = 1'b1;
    cyc(1);
    check("stream_first_pc",   32'(instr_pc),   32'h00);
    check("stream_first_data", 32'(instr_data), 32'hA5);
    cyc(9);
    check("stream_fc10", 32'(fetch_count), 32'd10);
    check("stream_pc9",  32'(instr_pc),    32'h09);

    // Backpressure
    rst_n = 1'b0; cyc(1);
    rst_n = 1'b1; instr_ready = 1'b0;
    cyc(5);
    check("bp_rom_stall", 32'(rom_address), 32'h02);
    check("bp_head",      32'(instr_pc),    32'h00);
    instr_ready = 1'b1;
    cyc(4);

    // Jump with full buffer
    instr_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 8'h14;
    cyc(1);
    redirect_valid = 1'b0;
    cyc(2);
    check("jmp_full_head", 32'(instr_pc), 32'h14);
    redirect_valid = 1'b1; redirect_pc = 8'h04;
    cyc(1);
    check("jmp_bubble", 32'(instr_valid), 32'h0);
    redirect_valid = 1'b0; instr_ready = 1'b1;
    cyc(1);
    check("jmp_pc",   32'(instr_pc),   32'h04);
    check("jmp_data", 32'(instr_data), 32'hA1);

    // Halt with two entries buffered
    instr_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 8'h06;
    cyc(1);
    redirect_valid = 1'b0;
    cyc(2);
    halt = 1'b1; instr_ready = 1'b1;
    cyc(1);
    check("halt_head7", 32'(instr_pc), 32'h07);
    check("halt_run",   32'(running),  32'h0);
    cyc(3);
    check("halt_rom", 32'(rom_address), 32'h08);
    halt = 1'b0;
    cyc(2);
    check("halt_resume", 32'(instr_pc), 32'h08);

    // PC wrap
    redirect_valid = 1'b1; redirect_pc = 8'hFE;
    cyc(1);
    redirect_valid = 1'b0;
    cyc(2);
    check("wrap_pulse_hi", 32'(wrap_pulse), 32'h1);
    check("wrap_pc_ff",    32'(instr_pc),   32'hFF);
    cyc(3);

    // Mid-run reset, then redirect with halt together
    instr_ready = 1'b0;
    cyc(2);
    rst_n = 1'b0;
    cyc(1);
    check("mrst_valid", 32'(instr_valid), 32'h0);
    check("mrst_rom",   32'(rom_address), 32'h0);
    check("mrst_fc",    32'(fetch_count), 32'h0);
    rst_n = 1'b1;
    cyc(2);
    redirect_valid = 1'b1; halt = 1'b1; redirect_pc = 8'h33; instr_ready = 1'b1;
    cyc(1);
    check("rh_run", 32'(running),     32'h0);
    check("rh_rom", 32'(rom_address), 32'h33);
    redirect_valid = 1'b0;
    cyc(2);
    halt = 1'b0;
    cyc(3);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n          = ($urandom_range(0, 149) != 0);
      instr_ready    = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? 8'hFD : ADDR_W'($urandom);
      if ($urandom_range(0, 9) == 0) halt = ~halt;
      cyc(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
